// File: rtl/denormalize.sv
// Block-floating-point to fixed-point converter. It arithmetic-right-shifts the
// mantissa by the clamped exponent, one bit per clock, with optional round-half-up.
// Latency is clamp(iExp)+1 cycles. iStart is ignored while oBusy=1, and nothing is queued.
// Ports: Clock/Reset (sync, active-low) | iStart, iMant, iExp request |
//        oBusy while shifting, oDone one-cycle pulse, oVect result (held).
module denormalize #(
   parameter int SIZE  = 10,
   parameter int ROUND = 0
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            iStart,
   input  logic [SIZE-1:0] iMant,
   input  logic [4:0]      iExp,
   output logic            oBusy,
   output logic            oDone,
   output logic [SIZE-1:0] oVect
);

   // The count never exceeds SIZE-1, so $clog2(SIZE) bits are enough.
   localparam int CW = $clog2(SIZE);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] sh_q, sh_d;
   logic            rb_q, rb_d;
   logic [CW-1:0]   count_q, count_d;
   logic            done_q, done_d;
   logic [SIZE-1:0] vect_q, vect_d;

   logic [31:0]     exp_ext;
   logic            rnd_bit;

   assign exp_ext = 32'(iExp);
   // rb is the last bit shifted out. It is still 0 when no shift happened, so
   // no rounding is applied in that case. For k>=1 the add cannot overflow.
   assign rnd_bit = rb_q & (ROUND != 0);

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      rb_d    = rb_q;
      count_d = count_q;
      done_d  = 1'b0;
      vect_d  = vect_q;
      case (state_q)
         S_IDLE: begin
            if (iStart) begin
               sh_d    = iMant;
               rb_d    = 1'b0;
               // Shifting by SIZE-1 already gives pure sign fill, so clamp there.
               if (exp_ext > 32'(SIZE - 1)) begin
                  count_d = CW'(SIZE - 1);
               end else begin
                  count_d = CW'(iExp);
               end
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (count_q != '0) begin
               sh_d    = {sh_q[SIZE-1], sh_q[SIZE-1:1]};
               rb_d    = sh_q[0];
               count_d = count_q - 1'b1;
            end else begin
               vect_d  = sh_q + {{(SIZE-1){1'b0}}, rnd_bit};
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         rb_q    <= 1'b0;
         count_q <= '0;
         done_q  <= 1'b0;
         vect_q  <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         rb_q    <= rb_d;
         count_q <= count_d;
         done_q  <= done_d;
         vect_q  <= vect_d;
      end
   end

   assign oBusy = (state_q == S_SHIFT);
   assign oDone = done_q;
   assign oVect = vect_q;

endmodule
